// File: rtl/fifo_enq_packer_if.sv
// Packet-in / FIFO-write-out bundle for fifo_enq_packer.
// master: the packer itself; slave: the producer and FIFO side.
interface fifo_enq_packer_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned IN_CNT = 4,
  parameter int unsigned W_CNT  = 2
);
  logic                    i_pkt_valid;
  logic [IN_CNT-1:0]       i_pkt_mask;
  logic [WIDTH-1:0]        i_pkt_data [0:IN_CNT-1];
  logic                    o_pkt_ready;
  logic [W_CNT-1:0]        o_w_e;
  logic [WIDTH-1:0]        o_w_data   [0:W_CNT-1];
  logic [W_CNT-1:0]        i_w_ack;
  logic                    i_flush;
  logic                    o_busy;

  modport master (
    input  i_pkt_valid, i_pkt_mask, i_pkt_data, i_w_ack, i_flush,
    output o_pkt_ready, o_w_e, o_w_data, o_busy
  );

  modport slave (
    output i_pkt_valid, i_pkt_mask, i_pkt_data, i_w_ack, i_flush,
    input  o_pkt_ready, o_w_e, o_w_data, o_busy
  );
endinterface

// File: rtl/fifo_enq_packer.sv
// Compacts one sparse packet and streams its valid entries, in slot order,
// into the write lanes of a banked FIFO, retrying unacknowledged lanes.
module fifo_enq_packer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned IN_CNT = 4,
  parameter int unsigned W_CNT  = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fifo_enq_packer_if.master bus
);

  localparam int unsigned PCW = $clog2(IN_CNT + 1);
  localparam int unsigned AW  = $clog2(W_CNT + 1);
  localparam int unsigned SW  = (IN_CNT > 1) ? $clog2(IN_CNT) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]        state;
  logic [IN_CNT-1:0] pend_mask;
  logic [WIDTH-1:0]  pkt_data [0:IN_CNT-1];

  logic [SW-1:0]     lane_slot [0:W_CNT-1];
  logic [W_CNT-1:0]  lane_vld;
  logic [W_CNT-1:0]  w_e_int;
  logic [PCW-1:0]    pend_cnt;
  logic [AW-1:0]     ack_cnt;
  logic [IN_CNT-1:0] clr_mask;
  logic              send;
  logic              done;
  logic              accept;

  assign send = (state == ST_SEND);

  // Lane k takes the k-th lowest pending slot; pend_cnt counts all pending slots.
  always_comb begin
    int unsigned cnt;
    cnt      = 0;
    lane_vld = '0;
    for (int unsigned k = 0; k < W_CNT; k++) lane_slot[k] = '0;
    for (int unsigned i = 0; i < IN_CNT; i++) begin
      if (pend_mask[i]) begin
        if (cnt < W_CNT) begin
          lane_slot[cnt] = SW'(i);
          lane_vld[cnt]  = 1'b1;
        end
        cnt++;
      end
    end
    pend_cnt = PCW'(cnt);
  end

  assign w_e_int = send ? lane_vld : '0;

  // Only the unbroken run of acks from lane 0 retires entries.
  always_comb begin
    int unsigned acnt;
    logic        run;
    acnt     = 0;
    run      = 1'b1;
    clr_mask = '0;
    for (int unsigned k = 0; k < W_CNT; k++) begin
      if (run && w_e_int[k] && bus.i_w_ack[k]) begin
        acnt++;
        clr_mask[lane_slot[k]] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    ack_cnt = AW'(acnt);
  end

  assign done            = send && (PCW'(ack_cnt) == pend_cnt);
  assign bus.o_pkt_ready = i_rst_n & ~bus.i_flush & (~send | done);
  assign accept          = bus.i_pkt_valid & bus.o_pkt_ready;
  assign bus.o_busy      = i_rst_n & send;

  always_comb begin
    for (int unsigned k = 0; k < W_CNT; k++) begin
      bus.o_w_e[k]    = i_rst_n & w_e_int[k];
      bus.o_w_data[k] = (i_rst_n && w_e_int[k]) ? pkt_data[lane_slot[k]] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      pend_mask <= '0;
      for (int unsigned i = 0; i < IN_CNT; i++) pkt_data[i] <= '0;
    end else if (bus.i_flush) begin
      state     <= ST_IDLE;
      pend_mask <= '0;
    end else if (accept) begin
      if (|bus.i_pkt_mask) begin
        state     <= ST_SEND;
        pend_mask <= bus.i_pkt_mask;
        for (int unsigned i = 0; i < IN_CNT; i++) pkt_data[i] <= bus.i_pkt_data[i];
      end else begin
        state     <= ST_IDLE;
        pend_mask <= '0;
      end
    end else if (send) begin
      pend_mask <= pend_mask & ~clr_mask;
      if (done) state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_fifo_enq_packer.sv
// Directed cycle-by-cycle vectors for fifo_enq_packer plus a FIFO-order scoreboard.
module tb_fifo_enq_packer;

  localparam logic [31:0] A_ = 32'hA000_000A;
  localparam logic [31:0] B_ = 32'hB000_000B;
  localparam logic [31:0] C_ = 32'hC000_000C;
  localparam logic [31:0] D_ = 32'hD000_000D;
  localparam logic [31:0] E_ = 32'hE000_000E;

  localparam logic [3:0][31:0] PABCD = {D_, C_, B_, A_};
  localparam logic [3:0][31:0] PSP   = {D_, 32'h2222_2222, B_, 32'h1111_1111};
  localparam logic [3:0][31:0] PE    = {32'h0, 32'h0, 32'h0, E_};
  localparam logic [3:0][31:0] PZ    = '0;

  typedef struct {
    logic             rst_n;
    logic             flush;
    logic             valid;
    logic [3:0]       mask;
    logic [3:0][31:0] data;
    logic [1:0]       ack;
    logic [1:0]       ew;
    logic [31:0]      ed0;
    logic [31:0]      ed1;
    logic             erdy;
    logic             ebusy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fifo_enq_packer_if #(.WIDTH(32), .IN_CNT(4), .W_CNT(2)) bus ();

  fifo_enq_packer #(.WIDTH(32), .IN_CNT(4), .W_CNT(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic f, logic v, logic [3:0] m,
                              logic [3:0][31:0] d, logic [1:0] ack,
                              logic [1:0] ew, logic [31:0] e0, logic [31:0] e1,
                              logic rdy, logic bsy);
    vec_t t;
    t.rst_n = r;  t.flush = f;  t.valid = v;  t.mask = m;  t.data = d;
    t.ack = ack;  t.ew = ew;    t.ed0 = e0;   t.ed1 = e1;
    t.erdy = rdy; t.ebusy = bsy;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst_n           = t.rst_n;
    bus.i_flush     = t.flush;
    bus.i_pkt_valid = t.valid;
    bus.i_pkt_mask  = t.mask;
    for (int i = 0; i < 4; i++) bus.i_pkt_data[i] = t.data[i];
    bus.i_w_ack     = t.ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] got[$];
    logic [31:0] exp_stream[$];
    bit          run;
    int          nwr;
    bit          seen_idle;

    //                r  f  v  mask     data   ack    w_e    d0  d1  rdy busy
    vecs.push_back(mk(0, 0, 1, 4'b1111, PABCD, 2'b00, 2'b00, 0,  0,  0, 0)); // reset
    vecs.push_back(mk(0, 0, 1, 4'b1111, PABCD, 2'b00, 2'b00, 0,  0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b1111, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // full packet
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b11, 2'b11, A_, B_, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b11, 2'b11, C_, D_, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b1010, PSP,   2'b00, 2'b00, 0,  0,  1, 0)); // sparse
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b11, 2'b11, B_, D_, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b0000, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // empty mask
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b11, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b0111, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // partial acks
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b01, 2'b11, A_, B_, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b10, 2'b11, B_, C_, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b11, B_, C_, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b11, 2'b11, B_, C_, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b0111, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // back-to-back
    vecs.push_back(mk(1, 0, 1, 4'b0001, PE,    2'b11, 2'b11, A_, B_, 0, 1));
    vecs.push_back(mk(1, 0, 1, 4'b0001, PE,    2'b11, 2'b01, C_, 0,  1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b01, 2'b01, E_, 0,  1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b1111, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // flush
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b11, 2'b11, A_, B_, 0, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0001, PE,    2'b00, 2'b11, C_, D_, 0, 1));
    vecs.push_back(mk(1, 0, 1, 4'b0001, PE,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b01, 2'b01, E_, 0,  1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b0011, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // flush on done
    vecs.push_back(mk(1, 1, 0, 4'b0000, PZ,    2'b11, 2'b11, A_, B_, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 4'b1111, PABCD, 2'b00, 2'b00, 0,  0,  1, 0)); // reset in SEND
    vecs.push_back(mk(0, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, PZ,    2'b00, 2'b00, 0,  0,  1, 0));

    exp_stream = '{A_, B_, C_, D_, B_, D_, A_, B_, C_, A_, B_, C_, E_,
                   A_, B_, E_, A_, B_};

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d w_e", i),    32'(bus.o_w_e),       32'(vecs[i].ew));
      chk($sformatf("v%0d data0", i),  bus.o_w_data[0],      vecs[i].ed0);
      chk($sformatf("v%0d data1", i),  bus.o_w_data[1],      vecs[i].ed1);
      chk($sformatf("v%0d ready", i),  32'(bus.o_pkt_ready), 32'(vecs[i].erdy));
      chk($sformatf("v%0d busy", i),   32'(bus.o_busy),      32'(vecs[i].ebusy));
      run = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (run && bus.o_w_e[k] && bus.i_w_ack[k]) got.push_back(bus.o_w_data[k]);
        else run = 1'b0;
      end
    end

    chk("fifo_count", 32'(got.size()), 32'(exp_stream.size()));
    for (int i = 0; i < exp_stream.size(); i++) begin
      if (i < got.size()) chk($sformatf("fifo_entry%0d", i), got[i], exp_stream[i]);
    end

    // Always-acking FIFO: a full packet must drain in two write beats.
    @(posedge clk);
    #1;
    rst_n           = 1'b1;
    bus.i_flush     = 1'b0;
    bus.i_pkt_valid = 1'b1;
    bus.i_pkt_mask  = 4'b1111;
    for (int i = 0; i < 4; i++) bus.i_pkt_data[i] = PABCD[i];
    bus.i_w_ack     = 2'b11;
    @(posedge clk);
    #1;
    bus.i_pkt_valid = 1'b0;
    nwr       = 0;
    seen_idle = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        seen_idle = 1'b1;
        break;
      end
      if (bus.o_w_e == 2'b11) nwr++;
      @(posedge clk);
      #1;
    end
    chk("drain_idle",  32'(seen_idle), 32'd1);
    chk("drain_beats", 32'(nwr),       32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_enq_packer.md
Name: fifo_enq_packer

Overview:
Producer-side driver for the write port of the multi-lane banked FIFO (W_CNT write lanes, per-lane enable bitmap, per-lane ack bitmap). It accepts one sparse packet of up to IN_CNT entries over a valid/ready handshake, compacts the valid entries, and streams them into the FIFO lanes in slot order. It retries entries the FIFO did not acknowledge until the whole packet is written. Typical placement is between fetch/decode packet output and the instruction queue.

Parameters:
WIDTH, 32, data width per entry
IN_CNT, 4, entry slots per input packet; must be at least W_CNT
W_CNT, 2, FIFO write lanes; must be at least 1

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_pkt_valid  input  1  input packet present
i_pkt_mask  input  IN_CNT  slot-valid bitmap; may be sparse; bit i qualifies i_pkt_data[i]
i_pkt_data  input  WIDTH x [0:IN_CNT-1]  packet entries (unpacked array)
o_pkt_ready  output  1  packet accepted when i_pkt_valid & o_pkt_ready
o_w_e  output  W_CNT  FIFO write-enable bitmap; always a contiguous prefix from lane 0
o_w_data  output  WIDTH x [0:W_CNT-1]  FIFO write data
i_w_ack  input  W_CNT  FIFO write-ack bitmap, combinational from o_w_e
i_flush  input  1  discard the pending packet
o_busy  output  1  a packet is pending (state SEND)

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset state: state=IDLE, pending=0, stored data=0.
- Outputs while i_rst_n=0: o_w_e=0, o_w_data all 0, o_pkt_ready=0, o_busy=0.
- Registered state:
  - state: IDLE or SEND
  - pend_mask: IN_CNT bits
  - pkt_data: IN_CNT x WIDTH
- Lane mapping (combinational, from registers only):
  - n = min(W_CNT, popcount(pend_mask)).
  - Lane k (k < n) carries the k-th lowest set slot of pend_mask.
  - o_w_e[k] = (state==SEND) & (k < n).
  - o_w_data[k] = 0 on disabled lanes.
  - o_w_e and o_w_data never depend on i_w_ack or on any input port.
- Ack accounting:
  - a = number of consecutive ones in (i_w_ack & o_w_e), counted from lane 0.
  - Ack bits after the first zero are ignored. Ack bits on disabled lanes are ignored.
  - The slots carried on lanes 0..a-1 are cleared from pend_mask at the clock edge.
- Counter widths: popcount and a use $clog2(IN_CNT+1) and $clog2(W_CNT+1) bits respectively; no wrap.
- done = (state==SEND) & (a == popcount(pend_mask)), i.e. the last pending entries are acked this cycle.
- o_pkt_ready = i_rst_n & ~i_flush & ((state==IDLE) | done). This is combinational from i_w_ack; there is no loop because o_w_e is register-only.
- Transitions (i_flush has highest priority):
  - i_flush=1: state goes to IDLE, pend_mask goes to 0. Any offered packet is not accepted. Any acks this cycle are still valid FIFO writes but are irrelevant.
  - Accept with i_pkt_mask != 0: load pkt_data and pend_mask = i_pkt_mask; state goes to SEND.
  - Accept with i_pkt_mask == 0: packet is consumed and dropped; state goes to IDLE.
  - SEND, not done, no accept: pend_mask updated by acks; stay in SEND.
  - SEND and done with no new packet: state goes to IDLE.
- Latency:
  - A packet accepted at edge N drives its first lanes in cycle N+1.
  - Back-to-back packets incur no bubble when accepted on the done cycle.
- Zero acks: pend_mask holds and the same lanes are re-presented with identical data every cycle.
- Data ordering: entries enter the FIFO in ascending slot order, with no duplication and no loss.
- o_busy = (state==SEND).

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_pkt_valid=1 -> o_w_e=00 and o_pkt_ready=0 throughout. After release: o_pkt_ready=1, o_busy=0.
- Full packet, full acks: mask=1111, data A,B,C,D; FIFO acks every enabled lane -> cycle1: o_w_e=11, data (A,B). Cycle2: o_w_e=11, data (C,D), o_pkt_ready=1. Cycle3: o_w_e=00, o_busy=0.
- Sparse packet: mask=1010, data slot1=B, slot3=D -> one cycle with o_w_e=11, data (B,D), then IDLE. Mask=0000 accepted -> o_w_e stays 00 and no SEND state is entered.
- Partial and non-prefix acks: mask=0111 (A,B,C):
  - Cycle1: lanes (A,B), i_w_ack=01.
  - Cycle2: lanes (B,C), i_w_ack=10, treated as a=0.
  - Cycle3: lanes (B,C) again, i_w_ack=11 -> done; FIFO has received A,B,C in order.
- Back-to-back: packet P2 (mask=0001, E) offered while the last entries of P1 are acked -> P2 accepted that cycle; next cycle o_w_e=01, data E.
- Flush mid-packet: mask=1111, 2 entries acked, then i_flush=1 with i_pkt_valid=1 -> o_pkt_ready=0 that cycle; next cycle o_w_e=00, o_busy=0; the offered packet is accepted only on the following cycle.
